pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have a parameter FLUSH_CYCLES, default 1, giving the extra cycles IF/ID is flushed after a taken branch (legal range 0..3).
REQ-002 The block SHALL have a parameter CNT_W, default 16, giving the width of the performance counters.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port id_rs, input, 5 bits: rs field of the instruction in ID.
REQ-007 Port id_rt, input, 5 bits: rt field of the instruction in ID.
REQ-008 Port id_uses_rs, input, 1 bit: the instruction in ID reads rs.
REQ-009 Port id_uses_rt, input, 1 bit: the instruction in ID reads rt.
REQ-010 Port ex_memread, input, 1 bit: the instruction in EX is a load.
REQ-011 Port ex_rd, input, 5 bits: destination register of the instruction in EX.
REQ-012 Port branch_taken, input, 1 bit: a branch or jump resolved taken in EX this cycle.
REQ-013 Port ibus_ready, input, 1 bit: instruction memory data on ibus is valid this cycle.
REQ-014 Port pc_en, output, 1 bit: PC register load enable.
REQ-015 Port ifid_en, output, 1 bit: IF/ID register load enable.
REQ-016 Port ifid_flush, output, 1 bit: IF/ID loads NOP (32'h0) instead of ibus.
REQ-017 Port idex_bubble, output, 1 bit: ID/EX control fields are zeroed.
REQ-018 Port state, output, 2 bits: current FSM state (RUN=0, FLUSH=1, HOLD=2).
REQ-019 Port stall_cnt, output, CNT_W bits: cycles lost to load-use stalls or fetch holds.
REQ-020 Port flush_cnt, output, CNT_W bits: number of taken-branch flush events.

Function
REQ-021 Outputs pc_en, ifid_en, ifid_flush and idex_bubble SHALL be combinational from state and the current-cycle inputs, with no added latency.
REQ-022 The load-use hazard luh SHALL be ex_memread & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-023 In RUN with no event, the outputs SHALL be pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
REQ-024 Priority of same-cycle events SHALL be branch_taken > luh > !ibus_ready.
REQ-025 On branch_taken in any state: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1; flush_cnt increments; next state is FLUSH with the remaining-flush counter set to FLUSH_CYCLES, or RUN if FLUSH_CYCLES=0.
REQ-026 On luh in RUN (no branch): pc_en=0, ifid_en=0, idex_bubble=1 for exactly that cycle; stall_cnt increments; state stays RUN.
REQ-027 On !ibus_ready in RUN (no branch, no luh): pc_en=0, ifid_en=1, ifid_flush=1, idex_bubble=0; stall_cnt increments; next state is HOLD.
REQ-028 In FLUSH (no branch): pc_en=ibus_ready, ifid_en=1, ifid_flush=1; the counter decrements only when ibus_ready=1; the next state is RUN when the counter reaches 0.
REQ-029 In HOLD: the outputs SHALL match REQ-027 while ibus_ready=0; on ibus_ready=1 the outputs SHALL be the RUN outputs (luh rules apply) and the next state is RUN.
REQ-030 stall_cnt and flush_cnt SHALL saturate at all-ones and never wrap.
REQ-031 Encoding 3 of state SHALL be unreachable; if it is entered, the next state SHALL be RUN.

Reset
REQ-032 While rst_n=0, the block SHALL force state=RUN, the flush counter=0, stall_cnt=0, flush_cnt=0, pc_en=0, ifid_en=0, ifid_flush=1 and idex_bubble=1, asynchronously.
REQ-033 Reset asserted mid-FLUSH or mid-HOLD SHALL abandon the sequence, and the first cycle after release SHALL follow RUN rules.

Verification
REQ-034 Load-use: ex_memread=1, ex_rd=8, id_rs=8, id_uses_rs=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_bubble=1 for that cycle only; stall_cnt=1.
REQ-035 Zero register: ex_memread=1, ex_rd=0, id_rs=0 -> no stall; stall_cnt stays 0.
REQ-036 Branch with FLUSH_CYCLES=1 and ibus_ready=1 -> ifid_flush=1 for 2 consecutive cycles, then state=RUN; flush_cnt=1.
REQ-037 Branch and luh in the same cycle -> branch outputs (pc_en=1, ifid_flush=1); stall_cnt unchanged.
REQ-038 ibus_ready=0 for 3 cycles, then 1 -> pc_en=0 and ifid_flush=1 for 3 cycles, state=HOLD, stall_cnt=3, then RUN outputs.
REQ-039 Preloaded stall_cnt=16'hFFFF plus another stall -> stall_cnt stays 16'hFFFF; rst_n pulsed low mid-HOLD -> outputs take the reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order pipeline.
// It resolves load-use stalls, taken-branch flushes and instruction-fetch
// holds into PC / IF-ID / ID-EX control, and keeps saturating performance
// counters for lost cycles and flush events.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             ibus_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             luh;
  logic             stall_inc;
  logic             flush_inc;

  // Load-use hazard: a load in EX writes a non-zero register that ID reads.
  assign luh = ex_memread && (ex_rd != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_rd)) ||
                (id_uses_rt && (id_rt == ex_rd)));

  // Next-state and pipeline control; outputs have no added latency.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (branch_taken) begin
      // Taken branch wins over every other event in every state.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
      if (FLUSH_CYCLES == 0) begin
        state_d = ST_RUN;
        fcnt_d  = 2'd0;
      end else begin
        state_d = ST_FLUSH;
        fcnt_d  = FLUSH_INIT;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (luh) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end else if (!ibus_ready) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            stall_inc  = 1'b1;
            state_d    = ST_HOLD;
          end
        end
        ST_FLUSH: begin
          // Keep squashing fetched words; only count down on real fetches.
          pc_en      = ibus_ready;
          ifid_flush = 1'b1;
          if (ibus_ready) begin
            if (fcnt_q <= 2'd1) begin
              fcnt_d  = 2'd0;
              state_d = ST_RUN;
            end else begin
              fcnt_d = fcnt_q - 2'd1;
            end
          end
        end
        ST_HOLD: begin
          if (!ibus_ready) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            stall_inc  = 1'b1;
          end else begin
            state_d = ST_RUN;
            if (luh) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idex_bubble = 1'b1;
              stall_inc   = 1'b1;
            end
          end
        end
        default: begin
          // Unused encoding: recover to RUN.
          state_d = ST_RUN;
          fcnt_d  = 2'd0;
        end
      endcase
    end

    // Reset drives the pipeline to a safe squashed state without a clock.
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // Saturating performance counter updates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush_inc && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // State, flush counter and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fcnt_q      <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// u0: default parameters. u1: FLUSH_CYCLES=0, CNT_W=4 for saturation checks.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, rst1_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_memread, branch_taken, ibus_ready;

  logic        pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  logic        pc_en1, ifid_en1, ifid_flush1, idex_bubble1;
  logic [1:0]  state1;
  logic [3:0]  stall_cnt1, flush_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .ibus_ready(ibus_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .state(state), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(0), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst1_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .ibus_ready(ibus_ready),
    .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
    .idex_bubble(idex_bubble1), .state(state1), .stall_cnt(stall_cnt1),
    .flush_cnt(flush_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the four control outputs of u0 against {pc_en, ifid_en, ifid_flush, idex_bubble}.
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, pc_en, ifid_en, ifid_flush, idex_bubble}, {28'd0, exp});
  endtask

  task automatic chk_ctl1(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, pc_en1, ifid_en1, ifid_flush1, idex_bubble1}, {28'd0, exp});
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    branch_taken = 1'b0; ibus_ready = 1'b1;
  endtask

  // Advance past the next rising edge and settle at negedge + 1.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
    ex_memread = 1'b1; ex_rd = rd; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
  endtask

  initial begin
    idle();
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    #1;
    $display("reset asserted");
    chk_ctl("reset_ctl", 4'b0011);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
    chk("reset_flush", {16'd0, flush_cnt}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    $display("run idle");
    chk_ctl("run_idle", 4'b1100);

    // Load-use on rs
    load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    #1;
    $display("load-use rs");
    chk_ctl("luh_rs_ctl", 4'b0001);
    tick();
    idle();
    #1;
    chk_ctl("luh_rs_after", 4'b1100);
    chk("luh_rs_stall", {16'd0, stall_cnt}, 32'd1);
    chk("luh_rs_state", {30'd0, state}, 32'd0);

    // Load-use on rt
    load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    $display("load-use rt");
    chk_ctl("luh_rt_ctl", 4'b0001);
    tick();
    idle();
    #1;
    chk("luh_rt_stall", {16'd0, stall_cnt}, 32'd2);

    // Matching rs but not read: no hazard
    load_use(5'd9, 5'd9, 1'b0, 5'd3, 1'b1);
    #1;
    $display("unused operand match");
    chk_ctl("nouse_ctl", 4'b1100);
    tick();
    idle();
    chk("nouse_stall", {16'd0, stall_cnt}, 32'd2);

    // Zero register never stalls
    load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    $display("zero register");
    chk_ctl("zero_ctl", 4'b1100);
    tick();
    idle();
    chk("zero_stall", {16'd0, stall_cnt}, 32'd2);

    // Taken branch, FLUSH_CYCLES=1, fetch ready
    branch_taken = 1'b1;
    #1;
    $display("branch");
    chk_ctl("br_ctl", 4'b1111);
    tick();
    idle();
    #1;
    chk("br_state_flush", {30'd0, state}, 32'd1);
    chk_ctl("br_flush2", 4'b1110);
    chk("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    tick();
    chk("br_state_run", {30'd0, state}, 32'd0);
    chk_ctl("br_done", 4'b1100);

    // Flush waits for fetch
    branch_taken = 1'b1;
    tick();
    idle();
    ibus_ready = 1'b0;
    #1;
    $display("flush waiting on ibus");
    chk_ctl("flwait_ctl", 4'b0110);
    tick();
    chk("flwait_state", {30'd0, state}, 32'd1);
    ibus_ready = 1'b1;
    #1;
    chk_ctl("flwait_go", 4'b1110);
    tick();
    chk("flwait_run", {30'd0, state}, 32'd0);
    chk("flwait_stall", {16'd0, stall_cnt}, 32'd2);

    // Branch and load-use together
    branch_taken = 1'b1;
    load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    #1;
    $display("branch with load-use");
    chk_ctl("brluh_ctl", 4'b1111);
    tick();
    idle();
    chk("brluh_stall", {16'd0, stall_cnt}, 32'd2);
    chk("brluh_flush", {16'd0, flush_cnt}, 32'd3);
    tick();
    chk("brluh_run", {30'd0, state}, 32'd0);

    // Fetch hold for three cycles
    ibus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      $display("hold cycle %0d", i);
      chk_ctl("hold_ctl", 4'b0110);
      tick();
      chk("hold_state", {30'd0, state}, 32'd2);
    end
    ibus_ready = 1'b1;
    #1;
    chk_ctl("hold_release", 4'b1100);
    chk("hold_stall", {16'd0, stall_cnt}, 32'd5);
    tick();
    chk("hold_run", {30'd0, state}, 32'd0);

    // Hold released into a load-use
    ibus_ready = 1'b0;
    tick();
    ibus_ready = 1'b1;
    load_use(5'd7, 5'd0, 1'b0, 5'd7, 1'b1);
    #1;
    $display("hold release with load-use");
    chk_ctl("holdluh_ctl", 4'b0001);
    tick();
    idle();
    chk("holdluh_state", {30'd0, state}, 32'd0);
    chk("holdluh_stall", {16'd0, stall_cnt}, 32'd7);

    // Branch during hold
    ibus_ready = 1'b0;
    tick();
    branch_taken = 1'b1;
    #1;
    $display("branch in hold");
    chk_ctl("holdbr_ctl", 4'b1111);
    tick();
    idle();
    chk("holdbr_state", {30'd0, state}, 32'd1);
    chk("holdbr_stall", {16'd0, stall_cnt}, 32'd8);
    chk("holdbr_flush", {16'd0, flush_cnt}, 32'd4);
    tick();

    // Asynchronous reset mid-hold
    ibus_ready = 1'b0;
    tick();
    chk("arst_pre_state", {30'd0, state}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset in hold");
    chk_ctl("arst_ctl", 4'b0011);
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("arst_flush", {16'd0, flush_cnt}, 32'd0);
    tick();
    ibus_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk_ctl("arst_run", 4'b1100);
    tick();
    chk("arst_run_state", {30'd0, state}, 32'd0);

    // Asynchronous reset mid-flush
    branch_taken = 1'b1;
    tick();
    idle();
    chk("frst_pre_state", {30'd0, state}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset in flush");
    chk("frst_state", {30'd0, state}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk_ctl("frst_run", 4'b1100);

    // Second instance: zero flush cycles and 4-bit saturating counters
    tick();
    rst1_n = 1'b1;
    branch_taken = 1'b1;
    #1;
    $display("u1 branch");
    chk_ctl1("u1_br_ctl", 4'b1111);
    tick();
    idle();
    #1;
    chk("u1_br_state", {30'd0, state1}, 32'd0);
    chk_ctl1("u1_br_after", 4'b1100);
    chk("u1_br_flush", {28'd0, flush_cnt1}, 32'd1);
    ibus_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    $display("u1 stall saturation");
    chk("u1_stall_sat", {28'd0, stall_cnt1}, 32'd15);
    ibus_ready = 1'b1;
    tick();
    load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    #1;
    chk_ctl1("u1_luh_ctl", 4'b0001);
    tick();
    idle();
    chk("u1_stall_hold", {28'd0, stall_cnt1}, 32'd15);
    branch_taken = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    idle();
    $display("u1 flush saturation");
    chk("u1_flush_sat", {28'd0, flush_cnt1}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
